// File: rtl/timecode_mem_arbiter.sv
// Round-robin arbiter sharing one single-port timecode memory between the
// capture ring writer and the host readback port; returns read data in order.
module timecode_mem_arbiter #(
   parameter int unsigned ADDR_W     = 13,
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned RING_BASE  = 0,
   parameter int unsigned RING_LEN   = 4096,
   parameter int unsigned RD_LATENCY = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] tc_data,
   input  logic              tc_valid,
   output logic              tc_ready,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_ack,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   input  logic              freeze,
   output logic [ADDR_W-1:0] wr_ptr,
   output logic              wrap_pulse,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [ADDR_W-1:0] RING_FIRST = ADDR_W'(RING_BASE);
   localparam logic [ADDR_W-1:0] RING_LAST  = ADDR_W'(RING_BASE + RING_LEN - 1);

   typedef enum logic {GNT_WR = 1'b0, GNT_RD = 1'b1} grant_e;

   grant_e              last_grant_q, last_grant_d;
   logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic                wrap_pulse_q, wrap_pulse_d;
   logic                mem_en_q, mem_en_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic [RD_LATENCY:0] tag_q, tag_d;
   logic                rd_valid_q, rd_valid_d;
   logic [DATA_W-1:0]   rd_data_q, rd_data_d;

   logic wr_elig, rd_elig, grant_wr, grant_rd;

   // Grants are exclusive; on a tie the side not served last wins.
   always_comb begin
      wr_elig  = tc_valid & ~freeze & ~reset;
      rd_elig  = rd_req & ~reset;
      grant_wr = wr_elig & (~rd_elig | (last_grant_q == GNT_RD));
      grant_rd = rd_elig & (~wr_elig | (last_grant_q == GNT_WR));
   end

   assign tc_ready = grant_wr;
   assign rd_ack   = grant_rd;

   always_comb begin
      last_grant_d = last_grant_q;
      wr_ptr_d     = wr_ptr_q;
      wrap_pulse_d = 1'b0;
      mem_en_d     = 1'b0;
      mem_we_d     = 1'b0;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      // Tag bit k marks a read whose memory access was k cycles ago.
      tag_d        = {tag_q[RD_LATENCY-1:0], grant_rd};
      rd_valid_d   = tag_q[RD_LATENCY];
      rd_data_d    = tag_q[RD_LATENCY] ? mem_rdata : rd_data_q;

      if (grant_wr) begin
         last_grant_d = GNT_WR;
         mem_en_d     = 1'b1;
         mem_we_d     = 1'b1;
         mem_addr_d   = wr_ptr_q;
         mem_wdata_d  = tc_data;
         if (wr_ptr_q == RING_LAST) begin
            wr_ptr_d     = RING_FIRST;
            wrap_pulse_d = 1'b1;
         end else begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
         end
      end else if (grant_rd) begin
         last_grant_d = GNT_RD;
         mem_en_d     = 1'b1;
         mem_addr_d   = rd_addr;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant_q <= GNT_RD;
         wr_ptr_q     <= RING_FIRST;
         wrap_pulse_q <= 1'b0;
         mem_en_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         tag_q        <= '0;
         rd_valid_q   <= 1'b0;
         rd_data_q    <= '0;
      end else begin
         last_grant_q <= last_grant_d;
         wr_ptr_q     <= wr_ptr_d;
         wrap_pulse_q <= wrap_pulse_d;
         mem_en_q     <= mem_en_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         tag_q        <= tag_d;
         rd_valid_q   <= rd_valid_d;
         rd_data_q    <= rd_data_d;
      end
   end

   assign wr_ptr     = wr_ptr_q;
   assign wrap_pulse = wrap_pulse_q;
   assign mem_en     = mem_en_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign rd_valid   = rd_valid_q;
   assign rd_data    = rd_data_q;

endmodule
